// File: rtl/mem_wb_stage_pkg.sv
// Shared types and widths for the MEM/WB back end: FSM state encoding and datapath widths.
package mem_wb_stage_pkg;

    localparam int          DATA_W           = 32;
    localparam int          REG_W            = 4;
    localparam logic [31:0] DEFAULT_MEM_BASE = 32'd1024;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/mem_wb_stage_if.sv
// EX-to-MEM request bundle plus the write-back bundle returned to the ID stage.
// Handshake: no valid/ready pair; the upstream stages hold every request field stable while freeze=1,
// and a request is consumed on the edge where freeze=0 (the commit edge).
interface mem_wb_stage_if;
    import mem_wb_stage_pkg::*;

    logic              wb_enable_in;
    logic              mem_read_enable;
    logic              mem_write_enable;
    logic [DATA_W-1:0] ALU_result;
    logic [DATA_W-1:0] Val_Rm;
    logic [REG_W-1:0]  Dest;
    logic              freeze;
    logic              wb_enable_out;
    logic [REG_W-1:0]  Dest_wb;
    logic [DATA_W-1:0] Result_WB;

    modport master (
        output wb_enable_in, mem_read_enable, mem_write_enable, ALU_result, Val_Rm, Dest,
        input  freeze, wb_enable_out, Dest_wb, Result_WB
    );

    modport slave (
        input  wb_enable_in, mem_read_enable, mem_write_enable, ALU_result, Val_Rm, Dest,
        output freeze, wb_enable_out, Dest_wb, Result_WB
    );

endinterface

// File: rtl/mem_wb_stage_data_mem_ctrl.sv
// Word-addressed data memory with a wait-state FSM; generates freeze while an access is in
// flight and a one-cycle commit strobe when the instruction may retire.
module data_mem_ctrl
    import mem_wb_stage_pkg::*;
#(
    parameter int          MEM_DEPTH   = 64,
    parameter logic [31:0] MEM_BASE    = DEFAULT_MEM_BASE,
    parameter int          WAIT_STATES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              freeze,
    output logic              commit,
    output logic              is_load,
    output logic [DATA_W-1:0] rdata,
    output state_e            state
);

    localparam int ADDR_W = $clog2(MEM_DEPTH);
    localparam int CNT_W  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  idx;
    logic               req;
    logic               freeze_raw;
    logic               commit_raw;
    logic [DATA_W-1:0]  mem [MEM_DEPTH];

    // Byte offset from the window base; low two bits dropped, high bits truncated so addresses wrap.
    assign idx     = ADDR_W'((addr - MEM_BASE) >> 2);
    assign req     = rd_en | wr_en;
    assign is_load = rd_en & ~wr_en;
    assign rdata   = mem[idx];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        freeze_raw = 1'b0;
        commit_raw = 1'b0;
        case (state_q)
            IDLE: begin
                if (!req || WAIT_STATES == 0) begin
                    commit_raw = 1'b1;
                end else begin
                    freeze_raw = 1'b1;
                    cnt_d      = CNT_W'(WAIT_STATES - 1);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    freeze_raw = 1'b1;
                    cnt_d      = cnt_q - 1'b1;
                end else begin
                    commit_raw = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Holding reset suppresses both strobes so an aborted store never reaches the array.
    assign freeze = freeze_raw & rst;
    assign commit = commit_raw & rst;
    assign state  = state_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (commit && wr_en) begin
            mem[idx] <= wdata;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB back end: drives the data-memory controller and holds the MEM/WB register whose
// write-back mux feeds the ID-stage register file.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int          MEM_DEPTH   = 64,
    parameter logic [31:0] MEM_BASE    = DEFAULT_MEM_BASE,
    parameter int          WAIT_STATES = 3
) (
    input  logic               clk,
    input  logic               rst,
    mem_wb_stage_if.slave      bus,
    output state_e             dbg_state
);

    logic              freeze;
    logic              commit;
    logic              is_load;
    logic [DATA_W-1:0] rdata;

    logic              wb_en_q, wb_en_d;
    logic              load_q, load_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic [REG_W-1:0]  dest_q, dest_d;

    data_mem_ctrl #(
        .MEM_DEPTH   (MEM_DEPTH),
        .MEM_BASE    (MEM_BASE),
        .WAIT_STATES (WAIT_STATES)
    ) u_mem_ctrl (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (bus.mem_read_enable),
        .wr_en   (bus.mem_write_enable),
        .addr    (bus.ALU_result),
        .wdata   (bus.Val_Rm),
        .freeze  (freeze),
        .commit  (commit),
        .is_load (is_load),
        .rdata   (rdata),
        .state   (dbg_state)
    );

    // Non-commit cycles insert a bubble: only the write enable drops, so the register file
    // sees each instruction exactly once.
    always_comb begin
        wb_en_d    = 1'b0;
        load_d     = load_q;
        alu_d      = alu_q;
        mem_data_d = mem_data_q;
        dest_d     = dest_q;
        if (commit) begin
            wb_en_d    = bus.wb_enable_in;
            load_d     = is_load;
            alu_d      = bus.ALU_result;
            mem_data_d = rdata;
            dest_d     = bus.Dest;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_en_q    <= 1'b0;
            load_q     <= 1'b0;
            alu_q      <= '0;
            mem_data_q <= '0;
            dest_q     <= '0;
        end else begin
            wb_en_q    <= wb_en_d;
            load_q     <= load_d;
            alu_q      <= alu_d;
            mem_data_q <= mem_data_d;
            dest_q     <= dest_d;
        end
    end

    assign bus.freeze        = freeze;
    assign bus.wb_enable_out = wb_en_q;
    assign bus.Dest_wb       = dest_q;
    assign bus.Result_WB     = load_q ? mem_data_q : alu_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: a 3-wait-state instance and a zero-wait instance against a word-array model.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  localparam int          WS_A  = 3;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'd1024;

  logic   clk = 1'b0;
  logic   rst;
  state_e dbg_a, dbg_b;

  always #5 clk = ~clk;

  mem_wb_stage_if if_a();
  mem_wb_stage_if if_b();

  mem_wb_stage #(.MEM_DEPTH(DEPTH), .MEM_BASE(BASE), .WAIT_STATES(WS_A)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave), .dbg_state(dbg_a)
  );

  mem_wb_stage #(.MEM_DEPTH(DEPTH), .MEM_BASE(BASE), .WAIT_STATES(0)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave), .dbg_state(dbg_b)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_model [DEPTH];
  bit          written   [DEPTH];
  logic [31:0] exp_q [$];

  function automatic int model_idx(input logic [31:0] a);
    return int'(((a - BASE) >> 2) % DEPTH);
  endfunction

  // Architectural effect of one instruction: returns the value the register file should receive.
  function automatic logic [31:0] model_op(input bit rd, input bit wr, input logic [31:0] alu,
                                           input logic [31:0] val);
    int k;
    k = model_idx(alu);
    if (wr) begin
      mem_model[k] = val;
      written[k]   = 1'b1;
      return alu;
    end
    if (rd) return mem_model[k];
    return alu;
  endfunction

  task automatic set_a(input bit wb, input bit rd, input bit wr, input logic [31:0] alu,
                       input logic [31:0] val, input logic [3:0] dest);
    if_a.wb_enable_in     = wb;
    if_a.mem_read_enable  = rd;
    if_a.mem_write_enable = wr;
    if_a.ALU_result       = alu;
    if_a.Val_Rm           = val;
    if_a.Dest             = dest;
  endtask

  // Presents one instruction, holds it through its freeze window, returns just after its commit edge.
  task automatic drive_op(input bit wb, input bit rd, input bit wr, input logic [31:0] alu,
                          input logic [31:0] val, input logic [3:0] dest,
                          output int frz, output int wbhi, output bit tmo);
    frz  = 0;
    wbhi = 0;
    tmo  = 1'b1;
    set_a(wb, rd, wr, alu, val, dest);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i > 0 && if_a.wb_enable_out) wbhi++;
      if (!if_a.freeze) begin
        tmo = 1'b0;
        break;
      end
      frz++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int frz, wbhi;
    bit tmo;
    drive_op(1'b1, 1'b0, 1'b0, 32'hCAFE, 32'h0, 4'd9, frz, wbhi, tmo);
    rst = 1'b0;
    set_a(1'b1, 1'b1, 1'b0, BASE, 32'h0, 4'd3);
    @(negedge clk);
    checks++;
    if (if_a.freeze !== 1'b0) begin
      errors++; $display("FAIL reset_freeze: got %b want 0", if_a.freeze);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (if_a.wb_enable_out !== 1'b0 || if_a.Dest_wb !== 4'd0 || if_a.Result_WB !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: got wb=%b dest=%0d res=%h want 0/0/0",
               if_a.wb_enable_out, if_a.Dest_wb, if_a.Result_WB);
    end
    checks++;
    if (dbg_a !== IDLE) begin
      errors++; $display("FAIL reset_state: got %0d want IDLE", dbg_a);
    end
    rst = 1'b1;
    set_a(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu_op();
    int frz, wbhi;
    bit tmo;
    drive_op(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 4'd5, frz, wbhi, tmo);
    checks++;
    if (tmo || frz != 0) begin
      errors++; $display("FAIL alu_freeze: got %0d freeze cycles (timeout=%b) want 0", frz, tmo);
    end
    checks++;
    if (if_a.Result_WB !== 32'h1234 || if_a.Dest_wb !== 4'd5 || if_a.wb_enable_out !== 1'b1) begin
      errors++;
      $display("FAIL alu_result: got res=%h dest=%0d wb=%b want 1234/5/1",
               if_a.Result_WB, if_a.Dest_wb, if_a.wb_enable_out);
    end
  endtask

  task automatic test_store_load();
    int frz, wbhi;
    bit tmo;
    logic [31:0] exp;
    exp = model_op(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
    drive_op(1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 4'd1, frz, wbhi, tmo);
    checks++;
    if (tmo || frz != WS_A || wbhi != 0 || if_a.wb_enable_out !== 1'b0) begin
      errors++;
      $display("FAIL store_window: got freeze=%0d wb_hi=%0d wb=%b tmo=%b want %0d/0/0/0",
               frz, wbhi, if_a.wb_enable_out, tmo, WS_A);
    end
    exp = model_op(1'b1, 1'b0, 32'd1028, 32'h0);
    drive_op(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd2, frz, wbhi, tmo);
    checks++;
    if (tmo || frz != WS_A || wbhi != 0) begin
      errors++; $display("FAIL load_window: got freeze=%0d wb_hi=%0d want %0d/0", frz, wbhi, WS_A);
    end
    checks++;
    if (if_a.Result_WB !== exp || if_a.Dest_wb !== 4'd2 || if_a.wb_enable_out !== 1'b1) begin
      errors++;
      $display("FAIL load_data: got res=%h dest=%0d wb=%b want %h/2/1",
               if_a.Result_WB, if_a.Dest_wb, if_a.wb_enable_out, exp);
    end
    drive_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, frz, wbhi, tmo);
    checks++;
    if (if_a.wb_enable_out !== 1'b0) begin
      errors++; $display("FAIL load_single_write: got wb=%b want 0", if_a.wb_enable_out);
    end
  endtask

  task automatic test_zero_wait();
    if_b.wb_enable_in = 1'b0; if_b.mem_read_enable = 1'b0; if_b.mem_write_enable = 1'b1;
    if_b.ALU_result = 32'd1032; if_b.Val_Rm = 32'h55; if_b.Dest = 4'd0;
    @(negedge clk);
    checks++;
    if (if_b.freeze !== 1'b0) begin
      errors++; $display("FAIL zw_store_freeze: got %b want 0", if_b.freeze);
    end
    @(posedge clk);
    #1;
    if_b.wb_enable_in = 1'b1; if_b.mem_read_enable = 1'b1; if_b.mem_write_enable = 1'b0;
    if_b.Val_Rm = 32'h0; if_b.Dest = 4'd3;
    @(negedge clk);
    checks++;
    if (if_b.freeze !== 1'b0 || if_b.wb_enable_out !== 1'b0) begin
      errors++; $display("FAIL zw_load_freeze: got freeze=%b wb=%b want 0/0", if_b.freeze, if_b.wb_enable_out);
    end
    @(posedge clk);
    #1;
    checks++;
    if (if_b.Result_WB !== 32'h55 || if_b.Dest_wb !== 4'd3 || if_b.wb_enable_out !== 1'b1) begin
      errors++;
      $display("FAIL zw_load_data: got res=%h dest=%0d wb=%b want 55/3/1",
               if_b.Result_WB, if_b.Dest_wb, if_b.wb_enable_out);
    end
    if_b.wb_enable_in = 1'b0; if_b.mem_read_enable = 1'b0;
  endtask

  task automatic test_reset_mid_store();
    int frz, wbhi;
    bit tmo;
    logic [31:0] exp;
    exp = model_op(1'b0, 1'b1, 32'd1036, 32'h1111);
    drive_op(1'b0, 1'b0, 1'b1, 32'd1036, 32'h1111, 4'd0, frz, wbhi, tmo);
    set_a(1'b0, 1'b0, 1'b1, 32'd1036, 32'hAAAA, 4'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (if_a.freeze !== 1'b0) begin
      errors++; $display("FAIL mid_store_freeze: got %b want 0", if_a.freeze);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_a(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    @(posedge clk);
    #1;
    exp = model_op(1'b1, 1'b0, 32'd1036, 32'h0);
    drive_op(1'b1, 1'b1, 1'b0, 32'd1036, 32'h0, 4'd7, frz, wbhi, tmo);
    checks++;
    if (tmo || if_a.Result_WB !== exp || if_a.Dest_wb !== 4'd7) begin
      errors++;
      $display("FAIL mid_store_abort: got res=%h dest=%0d tmo=%b want %h/7/0",
               if_a.Result_WB, if_a.Dest_wb, tmo, exp);
    end
  endtask

  task automatic test_wrap_conflict();
    int frz, wbhi;
    bit tmo;
    logic [31:0] exp;
    logic [31:0] wrap_addr;
    wrap_addr = BASE + 32'(4 * DEPTH);
    exp = model_op(1'b0, 1'b1, wrap_addr, 32'd7);
    drive_op(1'b0, 1'b0, 1'b1, wrap_addr, 32'd7, 4'd0, frz, wbhi, tmo);
    exp = model_op(1'b1, 1'b0, BASE, 32'h0);
    drive_op(1'b1, 1'b1, 1'b0, BASE, 32'h0, 4'd6, frz, wbhi, tmo);
    checks++;
    if (tmo || if_a.Result_WB !== exp || exp !== 32'd7) begin
      errors++; $display("FAIL wrap_load: got res=%h tmo=%b want 7", if_a.Result_WB, tmo);
    end
    exp = model_op(1'b1, 1'b1, BASE + 32'd8, 32'h99);
    drive_op(1'b1, 1'b1, 1'b1, BASE + 32'd8, 32'h99, 4'd4, frz, wbhi, tmo);
    checks++;
    if (tmo || frz != WS_A || if_a.Result_WB !== exp || if_a.wb_enable_out !== 1'b1) begin
      errors++;
      $display("FAIL conflict_result: got res=%h freeze=%0d wb=%b want %h/%0d/1",
               if_a.Result_WB, frz, if_a.wb_enable_out, exp, WS_A);
    end
    exp = model_op(1'b1, 1'b0, BASE + 32'd8, 32'h0);
    drive_op(1'b1, 1'b1, 1'b0, BASE + 32'd8, 32'h0, 4'd4, frz, wbhi, tmo);
    checks++;
    if (tmo || if_a.Result_WB !== exp) begin
      errors++; $display("FAIL conflict_store: got res=%h want %h", if_a.Result_WB, exp);
    end
  endtask

  task automatic test_back_to_back();
    int frz, wbhi;
    bit tmo, wb, rd, wr;
    logic [31:0] alu, val, exp;
    logic [3:0]  dest;
    int kind;
    for (int n = 0; n < 24; n++) begin
      kind = int'($urandom_range(0, 3));
      wb   = 1'($urandom_range(0, 1));
      rd   = (kind == 1) || (kind == 3);
      wr   = (kind == 2) || (kind == 3);
      alu  = BASE + 32'(4 * $urandom_range(0, 2 * DEPTH - 1)) + 32'($urandom_range(0, 3));
      if (kind == 0) alu = $urandom;
      val  = $urandom;
      dest = 4'($urandom_range(0, 15));
      if (rd && !wr && !written[model_idx(alu)]) wr = 1'b1;
      exp_q.push_back(model_op(rd, wr, alu, val));
      drive_op(wb, rd, wr, alu, val, dest, frz, wbhi, tmo);
      exp = exp_q.pop_front();
      checks++;
      if (tmo || frz != ((rd || wr) ? WS_A : 0) || wbhi != 0) begin
        errors++;
        $display("FAIL b2b_timing[%0d]: got freeze=%0d wb_hi=%0d tmo=%b want %0d/0/0",
                 n, frz, wbhi, tmo, (rd || wr) ? WS_A : 0);
      end
      checks++;
      if (if_a.Result_WB !== exp || if_a.Dest_wb !== dest || if_a.wb_enable_out !== wb) begin
        errors++;
        $display("FAIL b2b_result[%0d]: got res=%h dest=%0d wb=%b want %h/%0d/%b",
                 n, if_a.Result_WB, if_a.Dest_wb, if_a.wb_enable_out, exp, dest, wb);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    set_a(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    if_b.wb_enable_in = 1'b0; if_b.mem_read_enable = 1'b0; if_b.mem_write_enable = 1'b0;
    if_b.ALU_result = 32'h0; if_b.Val_Rm = 32'h0; if_b.Dest = 4'd0;
    for (int i = 0; i < DEPTH; i++) written[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_alu_op();
    test_store_load();
    test_zero_wait();
    test_reset_mid_store();
    test_wrap_conflict();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
